hilo_acc_file: RTL and testbench

//  Parametrised HI/LO accumulator file: NUM_ACC independent {HI,LO} pairs replacing the single HI/LO pair.

---
 rtl/hilo_pkg.sv | 18 +
 rtl/hilo_acc_pipe.sv | 69 ++++++
 rtl/hilo_acc_file.sv | 104 ++++++++++
 tb/tb_hilo_acc_file.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encodings and pair type for the HI/LO accumulator file
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_ACC_ADD = 2'b01,
        OP_ACC_SUB = 2'b10,
        OP_RSVD    = 2'b11
    } hilo_op_e;

    localparam int HILO_HALF_W = 32;

    typedef struct packed {
        logic [HILO_HALF_W-1:0] hi;
        logic [HILO_HALF_W-1:0] lo;
    } hilo_pair_t;

endpackage

// File: rtl/hilo_acc_pipe.sv
// rtl/hilo_acc_pipe.sv - one-stage accumulate commit pipe with the 2*DATA_W add/sub
module hilo_acc_pipe
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_valid,
    input  logic [1:0]        cap_op,
    input  logic [IDX_W-1:0]  cap_idx,
    input  logic [DATA_W-1:0] cap_hi,
    input  logic [DATA_W-1:0] cap_lo,
    input  logic [DATA_W-1:0] cur_hi,
    input  logic [DATA_W-1:0] cur_lo,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [DATA_W-1:0] commit_hi,
    output logic [DATA_W-1:0] commit_lo
);

    logic                  valid_q, valid_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            op_q, op_d;
    logic [2*DATA_W-1:0]   opnd_q, opnd_d;
    logic [2*DATA_W-1:0]   result;

    always_comb begin
        valid_d = cap_valid;
        idx_d   = idx_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        if (cap_valid) begin
            idx_d  = cap_idx;
            op_d   = cap_op;
            opnd_d = {cap_hi, cap_lo};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            op_q    <= 2'b00;
            opnd_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
        end
    end

    // The entry is read at commit time, so carry/borrow crosses LO->HI and wraps modulo 2^(2*DATA_W).
    always_comb begin
        if (op_q == OP_ACC_SUB) begin
            result = {cur_hi, cur_lo} - opnd_q;
        end else begin
            result = {cur_hi, cur_lo} + opnd_q;
        end
    end

    assign commit_valid = valid_q;
    assign commit_idx   = idx_q;
    assign commit_hi    = result[2*DATA_W-1:DATA_W];
    assign commit_lo    = result[DATA_W-1:0];

endmodule

// File: rtl/hilo_acc_file.sv
// rtl/hilo_acc_file.sv - NUM_ACC HI/LO accumulator pairs with write arbitration and read muxing
// Optional same-cycle read forwarding under macro HILO_BYPASS_EN.
module hilo_acc_file
    import hilo_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_ACC = 4,
    localparam int IDX_W  = $clog2(NUM_ACC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_op,
    input  logic [IDX_W-1:0]  wr_acc,
    input  logic              wr_hi_en,
    input  logic              wr_lo_en,
    input  logic [DATA_W-1:0] wr_hi,
    input  logic [DATA_W-1:0] wr_lo,
    input  logic [IDX_W-1:0]  rd_acc,
    output logic [DATA_W-1:0] rd_hi,
    output logic [DATA_W-1:0] rd_lo,
    output logic              rd_pending
);

    logic [DATA_W-1:0] hi_q [NUM_ACC];
    logic [DATA_W-1:0] hi_d [NUM_ACC];
    logic [DATA_W-1:0] lo_q [NUM_ACC];
    logic [DATA_W-1:0] lo_d [NUM_ACC];

    logic              accept, is_write, is_acc;
    logic              commit_valid;
    logic [IDX_W-1:0]  commit_idx;
    logic [DATA_W-1:0] commit_hi, commit_lo;

    // Stall only while the requested entry is the one being committed.
    assign wr_ready   = !(commit_valid && wr_acc == commit_idx);
    assign rd_pending = commit_valid && rd_acc == commit_idx;
    assign accept     = wr_valid && wr_ready;
    assign is_write   = accept && wr_op == OP_WRITE;
    assign is_acc     = accept && (wr_op == OP_ACC_ADD || wr_op == OP_ACC_SUB);

    hilo_acc_pipe #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_pipe (
        .clk          (clk),
        .rst          (rst),
        .cap_valid    (is_acc),
        .cap_op       (wr_op),
        .cap_idx      (wr_acc),
        .cap_hi       (wr_hi),
        .cap_lo       (wr_lo),
        .cur_hi       (hi_q[commit_idx]),
        .cur_lo       (lo_q[commit_idx]),
        .commit_valid (commit_valid),
        .commit_idx   (commit_idx),
        .commit_hi    (commit_hi),
        .commit_lo    (commit_lo)
    );

    // Commit and plain write never target the same entry: the stall keeps them apart.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit_valid) begin
            hi_d[commit_idx] = commit_hi;
            lo_d[commit_idx] = commit_lo;
        end
        if (is_write) begin
            if (wr_hi_en) hi_d[wr_acc] = wr_hi;
            if (wr_lo_en) lo_d[wr_acc] = wr_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                hi_q[i] <= '0;
                lo_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                hi_q[i] <= hi_d[i];
                lo_q[i] <= lo_d[i];
            end
        end
    end

    always_comb begin
        rd_hi = hi_q[rd_acc];
        rd_lo = lo_q[rd_acc];
`ifdef HILO_BYPASS_EN
        if (rd_pending) begin
            rd_hi = commit_hi;
            rd_lo = commit_lo;
        end else if (is_write && wr_acc == rd_acc) begin
            if (wr_hi_en) rd_hi = wr_hi;
            if (wr_lo_en) rd_lo = wr_lo;
        end
`endif
    end

endmodule

// File: tb/tb_hilo_acc_file.sv
// tb/tb_hilo_acc_file.sv - directed plus randomized bench against a behavioural HI/LO model
module tb_hilo_acc_file;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_op;
    logic [1:0]  wr_acc;
    logic        wr_hi_en, wr_lo_en;
    logic [31:0] wr_hi, wr_lo;
    logic [1:0]  rd_acc;
    logic [31:0] rd_hi, rd_lo;
    logic        rd_pending;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: 64-bit pairs plus one pending accumulate
    logic [63:0] m_pair [4];
    logic        p_v;
    int          p_idx;
    logic [1:0]  p_op;
    logic [63:0] p_opnd;

    hilo_acc_file #(.DATA_W(32), .NUM_ACC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_op      (wr_op),
        .wr_acc     (wr_acc),
        .wr_hi_en   (wr_hi_en),
        .wr_lo_en   (wr_lo_en),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .rd_acc     (rd_acc),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .rd_pending (rd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pend_result();
        if (p_op == OP_ACC_SUB) return m_pair[p_idx] - p_opnd;
        return m_pair[p_idx] + p_opnd;
    endfunction

    task automatic step(input logic r, input logic v, input logic [1:0] op, input int acc,
                        input logic he, input logic le, input logic [31:0] h, input logic [31:0] l,
                        input int ra);
        logic        exp_rdy, acc_ok;
        logic [63:0] exp_rd;
        rst = r; wr_valid = v; wr_op = op; wr_acc = acc[1:0];
        wr_hi_en = he; wr_lo_en = le; wr_hi = h; wr_lo = l; rd_acc = ra[1:0];
        #1;
        exp_rdy = !(p_v && acc == p_idx);
        acc_ok  = v && exp_rdy;
        exp_rd  = m_pair[ra];
`ifdef HILO_BYPASS_EN
        if (p_v && ra == p_idx) begin
            exp_rd = pend_result();
        end else if (acc_ok && op == OP_WRITE && acc == ra) begin
            if (he) exp_rd[63:32] = h;
            if (le) exp_rd[31:0]  = l;
        end
`endif
        if (!r) begin
            chk("wr_ready",   {63'd0, wr_ready},   {63'd0, exp_rdy});
            chk("rd_pending", {63'd0, rd_pending}, {63'd0, p_v && ra == p_idx});
            chk("rd_pair",    {rd_hi, rd_lo},      exp_rd);
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 4; i++) m_pair[i] = 64'd0;
            p_v = 1'b0;
        end else begin
            if (p_v) m_pair[p_idx] = pend_result();
            p_v = 1'b0;
            if (acc_ok && op == OP_WRITE) begin
                if (he) m_pair[acc][63:32] = h;
                if (le) m_pair[acc][31:0]  = l;
            end else if (acc_ok && (op == OP_ACC_ADD || op == OP_ACC_SUB)) begin
                p_v = 1'b1; p_idx = acc; p_op = op; p_opnd = {h, l};
            end
        end
    endtask

    task automatic idle_read(input int ra);
        step(1'b0, 1'b0, OP_WRITE, 0, 1'b0, 1'b0, 32'd0, 32'd0, ra);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_h, r_l;
        p_v = 1'b0; p_idx = 0; p_op = 2'b00; p_opnd = 64'd0;
        for (int i = 0; i < 4; i++) m_pair[i] = 64'd0;

        // Reset with a request present: it must be dropped
        step(1'b1, 1'b1, OP_WRITE, 2, 1'b1, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 0);
        step(1'b1, 1'b0, OP_WRITE, 0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        for (int i = 0; i < 4; i++) idle_read(i);

        // Partial-half write
        step(1'b0, 1'b1, OP_WRITE, 2, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 2);
        for (int i = 0; i < 4; i++) idle_read(i);
        chk("acc2_direct", m_pair[2], 64'hDEADBEEF_00000000);

        // Carry across LO->HI
        step(1'b0, 1'b1, OP_WRITE, 1, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1);
        step(1'b0, 1'b1, OP_ACC_ADD, 1, 1'b0, 1'b0, 32'h0, 32'h1, 1);
        idle_read(1);
        idle_read(1);
        chk("acc1_carry", m_pair[1], 64'h00000001_00000000);

        // Borrow wrap
        step(1'b0, 1'b1, OP_ACC_SUB, 0, 1'b1, 1'b1, 32'h0, 32'h1, 0);
        idle_read(0);
        idle_read(0);
        chk("acc0_wrap", m_pair[0], 64'hFFFFFFFF_FFFFFFFF);

        // Same-index write stalls one cycle and lands after the accumulate
        step(1'b0, 1'b1, OP_ACC_ADD, 3, 1'b0, 1'b0, 32'h1, 32'h2, 3);
        step(1'b0, 1'b1, OP_WRITE, 3, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 3);
        step(1'b0, 1'b1, OP_WRITE, 3, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 3);
        idle_read(3);
        chk("acc3_write_wins", m_pair[3], 64'hCAFEF00D_0BADBEEF);

        // Other-index write accepted in parallel with the commit
        step(1'b0, 1'b1, OP_ACC_ADD, 3, 1'b0, 1'b0, 32'h0, 32'h5, 3);
        step(1'b0, 1'b1, OP_WRITE, 0, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 0);
        idle_read(0);
        idle_read(3);

        // Back-to-back accumulates to different indices
        step(1'b0, 1'b1, OP_ACC_ADD, 0, 1'b0, 1'b0, 32'h0, 32'h10, 1);
        step(1'b0, 1'b1, OP_ACC_SUB, 1, 1'b0, 1'b0, 32'h0, 32'h3, 0);
        step(1'b0, 1'b1, OP_ACC_ADD, 2, 1'b0, 1'b0, 32'h1, 32'h1, 1);
        idle_read(2);

        // Reserved op
        step(1'b0, 1'b1, OP_RSVD, 2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        idle_read(2);

        // Random traffic, including corner operands
        for (int k = 0; k < 400; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_h  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            r_l  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            step(1'b0, 1'($urandom_range(0, 3) != 0), r_op, $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), r_h, r_l, $urandom_range(0, 3));
        end

        // Reset during an in-flight accumulate discards it
        step(1'b0, 1'b1, OP_WRITE, 2, 1'b1, 1'b1, 32'h0, 32'h0, 2);
        idle_read(2);
        step(1'b0, 1'b1, OP_ACC_ADD, 2, 1'b0, 1'b0, 32'h7, 32'h9, 2);
        step(1'b1, 1'b0, OP_WRITE, 0, 1'b0, 1'b0, 32'd0, 32'd0, 2);
        idle_read(2);
        chk("acc2_after_rst", m_pair[2], 64'd0);
        for (int i = 0; i < 4; i++) idle_read(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
